pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the RV32I IF/ID/EX pipeline.
//  - Detects load-use hazards between the decode-stage source registers and the EX-stage destination.
//  - Accepts branch/jump redirects from EX and external bus hold requests.
//  - Drives the PC/IF_ID/ID_EX hold and flush controls through a small FSM with stall/flush counters.
// PARAMETERS
//  FLUSH_LEN  1   total cycles if_id/id_ex flush is asserted per accepted jump (1..15)
//  LOAD_LAT   1   total stall cycles per load-use hazard (1..15)
//  CNT_W      32  width of performance counters (PIPE_PERF_CNT_EN only)
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      asynchronous active-low reset
//  id_rs1_addr_i   in   5      decode rs1 address (0 = unused)
//  id_rs2_addr_i   in   5      decode rs2 address (0 = unused)
//  ex_rd_addr_i    in   5      EX-stage destination register
//  ex_reg_wen_i    in   1      EX-stage writes rd
//  ex_is_load_i    in   1      EX-stage instruction is a load
//  ex_jump_en_i    in   1      EX resolves taken branch/jal
//  ex_jump_addr_i  in   32     redirect target
//  hold_req_i      in   1      bus/memory requests full pipeline freeze
//  hold_ack_o      out  1      freeze in effect (registered)
//  jump_en_o       out  1      PC redirect strobe
//  jump_addr_o     out  32     PC redirect target (0 when jump_en_o=0)
//  pc_hold_o       out  1      PC holds its value
//  if_id_hold_o    out  1      IF/ID register holds
//  id_ex_hold_o    out  1      ID/EX register holds
//  if_id_flush_o   out  1      IF/ID loads NOP
//  id_ex_flush_o   out  1      ID/EX loads NOP (bubble)
//  stall_cnt_o     out  CNT_W  cycles with pc_hold_o=1 (PIPE_PERF_CNT_EN only)
//  flush_cnt_o     out  CNT_W  accepted jumps (PIPE_PERF_CNT_EN only)
// BEHAVIOUR
//  - rst_n=0: state=RUN, counters=0, every output 0 (combinational outputs gated by rst_n).
//  - FSM states: RUN, LU_STALL, FLUSH, HOLD.
//  - Per-cycle priority: hold > jump > load-use.
//  - lu_hit = ex_is_load_i & ex_reg_wen_i & ex_rd_addr_i!=0 & (ex_rd_addr_i==id_rs1_addr_i | ex_rd_addr_i==id_rs2_addr_i).
//  - RUN:
//    - hold_req_i=1: pc/if_id/id_ex hold=1 same cycle, ->HOLD.
//    - else ex_jump_en_i=1: jump_en_o=1, jump_addr_o=ex_jump_addr_i, both flushes=1 same cycle;
//      FLUSH_LEN>1 ->FLUSH with fcnt=FLUSH_LEN-1, else stay RUN.
//    - else lu_hit: pc_hold=if_id_hold=1, id_ex_flush=1 same cycle;
//      LOAD_LAT>1 ->LU_STALL with scnt=LOAD_LAT-1, else stay RUN.
//  - LU_STALL:
//    - Outputs as lu_hit case; scnt decrements each cycle, ->RUN when scnt reaches 1.
//    - jump (abort stall, act as RUN jump) and hold (->HOLD) override.
//  - FLUSH:
//    - Both flushes=1, jump_en_o=0; fcnt decrements, ->RUN at 1.
//    - A new jump restarts fcnt=FLUSH_LEN-1 and redirects again.
//    - Hold overrides (->HOLD); the remaining flush is dropped.
//  - HOLD:
//    - hold_ack_o=1 (registered, 1 cycle after request).
//    - All three holds=1 while hold_req_i=1; ex_jump_en_i and lu_hit ignored, since EX is frozen and re-presents them.
//    - hold_req_i=0: holds drop same cycle, ->RUN, hold_ack_o=0 next cycle.
//  - Flush and hold on the same register never co-assert; hold wins.
//  - jump_addr_o is passed through unmodified; no alignment check.
//  - Reset mid-operation: immediate return to RUN, any pending stall/flush discarded.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//    - stall_cnt_o +1 per cycle pc_hold_o=1; flush_cnt_o +1 per accepted jump.
//    - Both wrap modulo 2^CNT_W; reset to 0.
//  PIPE_PERF_CNT_EN undefined: counter ports tied to 0, no counter flops.
// TESTING
//  - lw x5 in EX, add rs1=x5 in ID, LOAD_LAT=1 -> 1 cycle pc_hold/if_id_hold/id_ex_flush=1, then RUN.
//  - ex_rd=0 load, id_rs1=0 -> no stall; ex_reg_wen_i=0 with matching rd -> no stall.
//  - jump to 0x0000_0100, FLUSH_LEN=2 -> jump_en_o=1/addr=0x100 cycle 0; flushes=1 cycles 0-1; RUN cycle 2.
//  - jump and lu_hit in same cycle -> jump taken, no pc_hold.
//  - hold_req_i high 4 cycles with jump pending -> holds 4 cycles, hold_ack_o from cycle 1, jump accepted after release.
//  - rst_n low during LU_STALL with LOAD_LAT=3 -> outputs 0 immediately, RUN after release.
//  - PIPE_PERF_CNT_EN: 3 jumps + 2 stalls -> flush_cnt_o=3, stall_cnt_o=2; CNT_W=4 wraps after 16.

Source files
------------

// File: rtl/pipe_ctrl.sv
// RV32I IF/ID/EX pipeline sequencer: load-use stalls, jump flushes, bus holds.
// Optional PIPE_PERF_CNT_EN adds stall/flush performance counters.
module pipe_ctrl #(
    parameter int unsigned FLUSH_LEN = 1,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_reg_wen_i,
    input  logic             ex_is_load_i,
    input  logic             ex_jump_en_i,
    input  logic [31:0]      ex_jump_addr_i,
    input  logic             hold_req_i,
    output logic             hold_ack_o,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             pc_hold_o,
    output logic             if_id_hold_o,
    output logic             id_ex_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [3:0] FCNT_INIT = 4'(FLUSH_LEN - 1);
    localparam logic [3:0] SCNT_INIT = 4'(LOAD_LAT - 1);
    localparam bit         FLUSH_MC  = (FLUSH_LEN > 1);
    localparam bit         STALL_MC  = (LOAD_LAT > 1);

    state_t     state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic [3:0] scnt_q, scnt_d;
    logic       hold_ack_q, hold_ack_d;

    logic lu_hit;
    logic do_hold;
    logic do_jump;
    logic do_stall;
    logic do_flush;

    assign lu_hit = ex_is_load_i & ex_reg_wen_i
                  & (ex_rd_addr_i != 5'd0)
                  & ((ex_rd_addr_i == id_rs1_addr_i)
                   | (ex_rd_addr_i == id_rs2_addr_i));

    // Priority hold > jump > load-use; HOLD behaves like RUN once released.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        scnt_d   = scnt_q;
        do_hold  = 1'b0;
        do_jump  = 1'b0;
        do_stall = 1'b0;
        do_flush = 1'b0;
        if (hold_req_i) begin
            do_hold = 1'b1;
            state_d = HOLD;
        end else if (ex_jump_en_i) begin
            do_jump  = 1'b1;
            do_flush = 1'b1;
            fcnt_d   = FCNT_INIT;
            state_d  = FLUSH_MC ? FLUSH : RUN;
        end else begin
            unique case (state_q)
                FLUSH: begin
                    do_flush = 1'b1;
                    if (fcnt_q <= 4'd1) begin
                        state_d = RUN;
                    end else begin
                        fcnt_d = fcnt_q - 4'd1;
                    end
                end
                LU_STALL: begin
                    do_stall = 1'b1;
                    if (scnt_q <= 4'd1) begin
                        state_d = RUN;
                    end else begin
                        scnt_d = scnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (lu_hit) begin
                        do_stall = 1'b1;
                        scnt_d   = SCNT_INIT;
                        state_d  = STALL_MC ? LU_STALL : RUN;
                    end
                end
            endcase
        end
        hold_ack_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fcnt_q     <= 4'd0;
            scnt_q     <= 4'd0;
            hold_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            scnt_q     <= scnt_d;
            hold_ack_q <= hold_ack_d;
        end
    end

    assign hold_ack_o    = hold_ack_q;
    assign jump_en_o     = rst_n & do_jump;
    assign jump_addr_o   = jump_en_o ? ex_jump_addr_i : 32'd0;
    assign pc_hold_o     = rst_n & (do_hold | do_stall);
    assign if_id_hold_o  = rst_n & (do_hold | do_stall);
    assign id_ex_hold_o  = rst_n & do_hold;
    assign if_id_flush_o = rst_n & do_flush;
    assign id_ex_flush_o = rst_n & (do_flush | do_stall);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, pc_hold_o};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, jump_en_o};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
